// File: rtl/rv32ima_pkg.sv
// Shared types and constants for the rv32ima memory subsystem.
package rv32ima_pkg;

    localparam int RAM_ADDR_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        MERGE,
        ACK
    } ram_arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } ram_owner_t;

endpackage

// File: rtl/ram_byte_merge.sv
// Byte-lane merge for read-modify-write: enabled lanes take the new word,
// the rest keep the word read back from RAM.
module ram_byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged
);

    for (genvar k = 0; k < DATA_W/8; k++) begin : g_lane
        assign merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the fetch and
// data ports; sub-word stores are done as read-modify-write.
module ram_arbiter
    import rv32ima_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_req,
    input  logic [31:0]         i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wen,
    input  logic [31:0]         d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_store,
    output logic                ram_wen,
    input  logic [DATA_W-1:0]   ram_load
);

    localparam logic [DATA_W/8-1:0] BE_ALL  = '1;
    localparam logic [DATA_W/8-1:0] BE_NONE = '0;

    ram_arb_state_t      state_q, state_d;
    ram_owner_t          owner_q, last_q, gnt_owner;
    logic                en_q;
    logic                gnt;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   merged;
    logic [ADDR_W-1:0]   i_word, d_word;

    // Byte offset and high bits are dropped, so upper addresses alias.
    assign i_word = i_addr[ADDR_W+1:2];
    assign d_word = d_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    ram_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (ram_load),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    // Grant only from IDLE once out of reset; on conflict the port not
    // served last wins.
    always_comb begin
        gnt       = 1'b0;
        gnt_owner = OWN_FETCH;
        if (state_q == IDLE && en_q && (i_req || d_req)) begin
            gnt = 1'b1;
            if (d_req && (!i_req || last_q == OWN_FETCH))
                gnt_owner = OWN_DATA;
        end
    end

    // Next state and all outputs; everything idles at zero.
    always_comb begin
        state_d   = state_q;
        ram_addr  = '0;
        ram_store = '0;
        ram_wen   = 1'b0;
        i_ready   = 1'b0;
        i_rdata   = '0;
        d_ready   = 1'b0;
        d_rdata   = '0;
        case (state_q)
            IDLE: begin
                if (gnt) begin
                    state_d = ACK;
                    if (gnt_owner == OWN_FETCH) begin
                        ram_addr = i_word;
                    end else begin
                        ram_addr = d_word;
                        if (d_wen && d_be == BE_ALL) begin
                            ram_wen   = 1'b1;
                            ram_store = d_wdata;
                        end else if (d_wen && d_be != BE_NONE) begin
                            state_d = MERGE;
                        end
                    end
                end
            end
            MERGE: begin
                ram_addr  = addr_q;
                ram_store = merged;
                ram_wen   = 1'b1;
                state_d   = ACK;
            end
            ACK: begin
                state_d = IDLE;
                if (owner_q == OWN_FETCH) begin
                    i_ready = 1'b1;
                    i_rdata = ram_load;
                end else begin
                    d_ready = 1'b1;
                    if (!wen_q) d_rdata = ram_load;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, enable, and the request copy captured at grant.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            last_q  <= OWN_FETCH;
            owner_q <= OWN_FETCH;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
            if (gnt) begin
                owner_q <= gnt_owner;
                last_q  <= gnt_owner;
                if (gnt_owner == OWN_FETCH) begin
                    wen_q  <= 1'b0;
                    addr_q <= i_word;
                end else begin
                    wen_q   <= d_wen;
                    addr_q  <= d_word;
                    wdata_q <= d_wdata;
                    be_q    <= d_be;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_req, d_req, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_ready, d_ready, ram_wen;
    logic [31:0] i_rdata, d_rdata, ram_store, ram_load;
    logic [13:0] ram_addr;

    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = '0;
    logic [31:0] bd_data = '0;
    logic [31:0] mem [0:16383];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .nrst(nrst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_ready(d_ready), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_store(ram_store), .ram_wen(ram_wen),
        .ram_load(ram_load)
    );

    // Synchronous RAM, read-before-write, with a backdoor for preloading.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_wen) mem[ram_addr] <= ram_store;
        ram_load <= mem[ram_addr];
    end

    typedef struct {
        logic        is_fetch;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          lat;
        logic        wen0;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic f, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic [31:0] rd, input int lat, input logic w0);
        vec_t v;
        v.is_fetch = f; v.wen = w; v.addr = a; v.wdata = wd; v.be = be;
        v.rdata = rd; v.lat = lat; v.wen0 = w0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int   lat;
        logic got, other, nz;
        logic [31:0] rd;
        @(negedge clk);
        if (v.is_fetch) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_wen = v.wen; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end
        #1;
        chk($sformatf("v%0d grant_wen", idx), {63'd0, ram_wen}, {63'd0, v.wen0});
        chk($sformatf("v%0d grant_addr", idx), {50'd0, ram_addr}, {50'd0, v.addr[15:2]});
        lat = 0; got = 1'b0; other = 1'b0; nz = 1'b0; rd = '0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (v.is_fetch ? d_ready : i_ready) other = 1'b1;
            if (v.is_fetch ? i_ready : d_ready) begin
                got = 1'b1; lat = c; rd = v.is_fetch ? i_rdata : d_rdata;
            end else if ((v.is_fetch ? i_rdata : d_rdata) != 0) begin
                nz = 1'b1;
            end
            // Inputs may change after grant; the block must use its copies.
            if (c == 1) begin
                i_addr = 32'hFFFF_FFFC; d_addr = 32'hFFFF_FFFC;
                d_wdata = 32'h5A5A_5A5A; d_be = 4'hF;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d rdata", idx), {32'd0, rd}, {32'd0, v.rdata});
        chk($sformatf("v%0d other_ready", idx), {63'd0, other}, 64'd0);
        chk($sformatf("v%0d rdata_idle_zero", idx), {63'd0, nz}, 64'd0);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 32'h0000_0010, 0, 4'h0, 32'hDEAD_BEEF, 1, 0);
        vecs[1]  = mk(0, 1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0, 1, 1);
        vecs[2]  = mk(0, 0, 32'h0000_0020, 0, 4'h0, 32'h1234_5678, 1, 0);
        vecs[3]  = mk(0, 1, 32'h0000_0020, 32'h0000_AB00, 4'h2, 0, 2, 0);
        vecs[4]  = mk(0, 0, 32'h0000_0020, 0, 4'h0, 32'h1234_AB78, 1, 0);
        vecs[5]  = mk(0, 1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 0, 1, 0);
        vecs[6]  = mk(0, 0, 32'h0000_0020, 0, 4'h0, 32'h1234_AB78, 1, 0);
        vecs[7]  = mk(1, 0, 32'h0001_0022, 0, 4'h0, 32'h1234_AB78, 1, 0);
        vecs[8]  = mk(0, 1, 32'h0000_0024, 32'hAA00_00BB, 4'h9, 0, 2, 0);
        vecs[9]  = mk(0, 0, 32'h0000_0027, 0, 4'h0, 32'hAA22_33BB, 1, 0);
        vecs[10] = mk(0, 1, 32'h0000_0024, 32'hCCDD_EE00, 4'hE, 0, 2, 0);
        vecs[11] = mk(0, 0, 32'h0000_0024, 0, 4'h0, 32'hCCDD_EEBB, 1, 0);

        nrst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        #1;
        chk("reset_outputs", {32'd0, ram_wen, i_ready, d_ready, ram_addr, 15'd0},
            64'd0);
        chk("reset_data", {i_rdata | d_rdata, ram_store}, 64'd0);

        // Preload while still in reset.
        @(negedge clk); bd_we = 1'b1; bd_addr = 14'd4; bd_data = 32'hDEAD_BEEF;
        @(negedge clk); bd_addr = 14'd9; bd_data = 32'h1122_3344;
        @(negedge clk); bd_we = 1'b0;

        // Both ports requesting across reset release: data wins first.
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0030;
        d_wdata = 32'h5566_7788; d_be = 4'hF;
        @(negedge clk); nrst = 1'b1; #1;
        chk("release_no_wen", {63'd0, ram_wen}, 64'd0);
        @(negedge clk); #1;
        chk("conf_n_data_write", {49'd0, ram_wen, ram_addr}, {49'd0, 1'b1, 14'd12});
        @(negedge clk);
        chk("conf_n1_ready", {62'd0, d_ready, i_ready}, 64'd2);
        d_wen = 1'b0;
        @(negedge clk); #1;
        chk("conf_n2_fetch_grant", {49'd0, ram_wen, ram_addr}, {49'd0, 1'b0, 14'd4});
        @(negedge clk);
        chk("conf_n3_ready", {62'd0, d_ready, i_ready}, 64'd1);
        chk("conf_n3_rdata", {32'd0, i_rdata}, {32'd0, 32'hDEAD_BEEF});
        @(negedge clk); #1;
        chk("conf_n4_data_grant", {49'd0, ram_wen, ram_addr}, {49'd0, 1'b0, 14'd12});
        @(negedge clk);
        chk("conf_n5_ready", {62'd0, d_ready, i_ready}, 64'd2);
        chk("conf_n5_rdata", {32'd0, d_rdata}, {32'd0, 32'h5566_7788});
        i_req = 1'b0; d_req = 1'b0;

        for (int k = 0; k < 12; k++) do_txn(k, vecs[k]);

        // Reset pulse while in MERGE aborts the partial store.
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0024;
        d_wdata = 32'h0000_00FF; d_be = 4'h1;
        @(negedge clk);
        chk("merge_wen", {63'd0, ram_wen}, 64'd1);
        #2 nrst = 1'b0; #1;
        chk("merge_reset_outputs", {31'd0, ram_wen, d_ready, i_ready, ram_addr, 16'd0},
            64'd0);
        chk("merge_reset_data", {ram_store, d_rdata}, 64'd0);
        @(negedge clk);
        d_req = 1'b0;
        chk("merge_reset_no_ready", {63'd0, d_ready}, 64'd0);
        nrst = 1'b1;
        @(negedge clk);
        chk("merge_reset_no_ready2", {63'd0, d_ready}, 64'd0);
        chk("merge_reset_mem", {32'd0, mem[9]}, {32'd0, 32'hCCDD_EEBB});
        do_txn(12, mk(0, 0, 32'h0000_0024, 0, 4'h0, 32'hCCDD_EEBB, 1, 0));
        do_txn(13, mk(0, 1, 32'h0000_0024, 32'h0000_00FF, 4'h1, 0, 2, 0));
        do_txn(14, mk(0, 0, 32'h0000_0024, 0, 4'h0, 32'hCCDD_EEFF, 1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port on-chip RAM between the instruction-fetch port and the data (load/store) port of the rv32ima core. Accepts byte-addressed requests from each port, arbitrates round-robin on conflict, and implements sub-word stores as read-modify-write, because the RAM macro has only a word-wide write enable. Sits between the core's memory stage and the cpu_ram_if RAM signals, with ram_clk tied to clk.

## Interface
- ADDR_W, 14: RAM word-address width.
- DATA_W, 32: RAM word width; fixed at 32 for rv32ima.
- clk  in  1  system clock, also drives ram_clk.
- nrst  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request, held until i_ready.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  one-cycle completion pulse; i_rdata valid in the same cycle.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request, held until d_ready.
- d_wen  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, already lane-aligned.
- d_be  in  4  store byte enables; ignored for loads.
- d_ready  out  1  one-cycle completion pulse.
- d_rdata  out  32  loaded word.
- ram_addr  out  ADDR_W  to RAM address.
- ram_store  out  32  to RAM data.
- ram_wen  out  1  to RAM write enable.
- ram_load  in  32  RAM q; valid one cycle after the address is presented.

## Operation
- Word address = byte_addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so upper addresses alias.
- States: IDLE, MERGE, ACK.
- IDLE: a grant is issued combinationally when en_q=1 and any request is present.
  - Only one request: that port wins.
  - Both requesting: the port not granted last wins (last_q pointer). The reset value of last_q = fetch, so data wins the first conflict.
  - At grant, the following are latched: owner, word address, wdata, be. last_q is updated.
  - ram_addr is driven from the granting port's address in the same cycle.
- Transitions out of IDLE:
  - Load or fetch: ram_wen=0 -> ACK.
  - Store with be=1111: ram_wen=1, ram_store=d_wdata -> ACK.
  - Store with be=0000: no RAM access -> ACK.
  - Any other store: read issued -> MERGE.
- MERGE: merged = per byte, be[k] ? wdata byte k : ram_load byte k. Drive ram_addr=latched address, ram_store=merged, ram_wen=1 -> ACK.
- ACK: owner's ready=1. For reads, owner's rdata=ram_load. No grant is issued -> IDLE.
- Outputs with no active drive:
  - rdata of a port = 0 whenever its ready=0.
  - ram_addr=0, ram_store=0, ram_wen=0 in IDLE with no grant and in ACK.
- en_q: a flop cleared by reset and set on the first clk edge after nrst deasserts. It blocks grants, and therefore ram_wen, while in or just leaving reset.
- A request dropped before ready is a protocol violation. The transaction still completes and the ready pulse is still issued.
- The port's address and data inputs may change after grant, because the block uses latched copies.

## Timing
- Reset (nrst=0, asynchronous): state=IDLE, en_q=0, last_q=fetch. All outputs are 0.
- Read, fetch and full-word store: request seen in IDLE cycle N -> ready in cycle N+1 (ACK).
- Partial store: IDLE at N, MERGE at N+1, ready at N+2.
- Minimum spacing between grants is 2 cycles: ACK always returns to IDLE.
- A requester sampling ready=1 may drop or replace its request on that edge. The next IDLE cycle sees the new value, so a stale regrant cannot occur.
- Simultaneous requests are served back-to-back, alternating by round-robin.
- Reset asserted mid-transaction aborts it immediately, with no ready pulse.
  - A write already clocked into the RAM persists.
  - A MERGE write not yet clocked is lost.

## Structure
- rv32ima_pkg gains:
  - ram_arb_state_t enum: IDLE, MERGE, ACK.
  - ram_owner_t enum: OWN_FETCH, OWN_DATA.
  - RAM_ADDR_W = 14.
- One sub-module, ram_byte_merge: combinational, inputs old word, new word and be; output merged word.
- Top level instantiates ram_arbiter and the existing ram wrapper, connecting ram_* to cpu_ram_if.

## Test plan
- Fetch only: i_addr=0x10, word 4 preloaded with 0xDEADBEEF -> i_ready at N+1, i_rdata=0xDEADBEEF. d_ready stays 0.
- Full store then load: store 0x12345678 to 0x20 with be=1111 -> d_ready at N+1. Then a load of 0x20 -> d_rdata=0x12345678.
- Partial store: word 0x20 = 0x12345678, store d_wdata=0x0000AB00, be=0010 -> d_ready at N+2. A readback returns 0x1234AB78.
- Conflict: i_req and d_req both asserted at the first enabled cycle and held.
  - Data is granted first.
  - Fetch is granted at N+2.
  - If both are re-requested, data is granted at N+4, then alternation continues.
- Reset: nrst=1 with i_req=1 and d_req=1 on the cycle nrst is released -> ram_wen=0 that cycle.
- Reset in MERGE: nrst pulsed during MERGE -> no d_ready, outputs 0, the RAM word is unchanged, and the next transaction completes normally.
